// File: rtl/bcd_cntr_pkg.sv
// Shared types, constants and helpers for the cascaded BCD up/down counter.
package bcd_cntr_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX  = 4'd9;
   localparam bcd_digit_t BCD_ZERO = 4'd0;

   // Clamp an arbitrary nibble into the legal BCD range (>9 becomes 9).
   function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the counter: holds its own value, steps by +/-1 with
// decimal wrap when told to, and reports whether it sits at 9 or 0.
// The top level owns the ripple-enable chain and the boundary policy.
module bcd_digit_cell
   import bcd_cntr_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       step,
   input  logic       up,
   input  logic       load,
   input  logic [3:0] load_digit,
   output logic [3:0] digit,
   output logic       at_max,
   output logic       at_min
);

   // NOTE: the power-up value comes from the declaration initialiser; there is
   // deliberately no asynchronous reset, only the synchronous clr below.
   bcd_digit_t digit_q = BCD_ZERO;
   bcd_digit_t digit_d;

   // Next digit value: clr > load > step, otherwise hold.
   always_comb begin
      // NOTE: default first so every path assigns digit_d and no latch is inferred.
      digit_d = digit_q;
      if (clr) begin
         digit_d = BCD_ZERO;
      end else if (load) begin
         digit_d = bcd_sanitize(load_digit);
      end else if (step) begin
         if (up) begin
            digit_d = (digit_q == BCD_MAX) ? BCD_ZERO : digit_q + 4'd1;
         end else begin
            digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : digit_q - 4'd1;
         end
      end
   end

   // Digit register.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment so all digits update together on the edge.
      digit_q <= digit_d;
   end

   assign digit  = digit_q;
   assign at_max = (digit_q == BCD_MAX);
   assign at_min = (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_updown_cntr.sv
// Cascaded NUM_DIGITS-digit BCD up/down counter with parallel load,
// wrap-or-saturate boundary handling and a sticky wrap flag.
// Optional feature: define BCD_UPDOWN_CNTR_MATCH_EN to add cmp_data/match,
// a registered equality compare of the count against cmp_data.
module bcd_updown_cntr
   import bcd_cntr_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SATURATE   = 0
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    cnt,
   input  logic                    up,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   output logic [4*NUM_DIGITS-1:0] o_data,
   output logic                    terminal_cnt,
   output logic                    wrapped
`ifdef BCD_UPDOWN_CNTR_MATCH_EN
   ,
   input  logic [4*NUM_DIGITS-1:0] cmp_data,
   output logic                    match
`endif
);

   logic [NUM_DIGITS-1:0] at_max;
   logic [NUM_DIGITS-1:0] at_min;
   logic [NUM_DIGITS-1:0] step_chain;
   logic                  at_boundary;
   logic                  hold_boundary;
   logic                  wrapped_q = 1'b0;
   logic                  wrapped_d;

   // Whole count is at the edge it is heading towards (all 9 going up,
   // all 0 going down); in saturate mode that step is suppressed entirely.
   assign at_boundary   = up ? (&at_max) : (&at_min);
   assign hold_boundary = (SATURATE != 0) && at_boundary;
   assign terminal_cnt  = ~clr & ~load & cnt & at_boundary;

   // Ripple enable: digit g steps when every lower digit is at its rollover value.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      if (g == 0) begin : g_lsd
         assign step_chain[g] = cnt & ~hold_boundary;
      end else begin : g_upper
         assign step_chain[g] = step_chain[g-1] & (up ? at_max[g-1] : at_min[g-1]);
      end

      bcd_digit_cell u_cell (
         .clk        (clk),
         .clr        (clr),
         .step       (step_chain[g]),
         .up         (up),
         .load       (load),
         .load_digit (load_data[4*g +: 4]),
         .digit      (o_data[4*g +: 4]),
         .at_max     (at_max[g]),
         .at_min     (at_min[g])
      );
   end

   // Sticky wrap flag: cleared by clr or load, set by any boundary step.
   always_comb begin
      wrapped_d = wrapped_q;
      if (clr || load) begin
         wrapped_d = 1'b0;
      end else if (terminal_cnt) begin
         wrapped_d = 1'b1;
      end
   end

   // Wrap flag register.
   always_ff @(posedge clk) begin
      wrapped_q <= wrapped_d;
   end

   assign wrapped = wrapped_q;

`ifdef BCD_UPDOWN_CNTR_MATCH_EN
   logic match_q = 1'b0;

   // Registered compare of the current count against cmp_data.
   always_ff @(posedge clk) begin
      if (clr) begin
         match_q <= 1'b0;
      end else begin
         match_q <= (o_data == cmp_data);
      end
   end

   assign match = match_q;
`endif

endmodule

// File: tb/tb_bcd_updown_cntr.sv
// Self-checking bench for bcd_updown_cntr: two 2-digit instances (wrap and
// saturate) share stimulus; a vector table plus model-driven count sequences.
module tb_bcd_updown_cntr;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic       cnt = 1'b0;
   logic       up = 1'b0;
   logic [7:0] load_data = 8'h00;
   logic [7:0] o_data_w, o_data_s;
   logic       tc_w, tc_s;
   logic       wrapped_w, wrapped_s;
`ifdef BCD_UPDOWN_CNTR_MATCH_EN
   logic [7:0] cmp_data = 8'h00;
   logic       match_w, match_s;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bcd_updown_cntr #(.NUM_DIGITS(2), .SATURATE(0)) dut_w (
      .clk          (clk),
      .clr          (clr),
      .cnt          (cnt),
      .up           (up),
      .load         (load),
      .load_data    (load_data),
      .o_data       (o_data_w),
      .terminal_cnt (tc_w),
      .wrapped      (wrapped_w)
`ifdef BCD_UPDOWN_CNTR_MATCH_EN
      ,
      .cmp_data     (cmp_data),
      .match        (match_w)
`endif
   );

   bcd_updown_cntr #(.NUM_DIGITS(2), .SATURATE(1)) dut_s (
      .clk          (clk),
      .clr          (clr),
      .cnt          (cnt),
      .up           (up),
      .load         (load),
      .load_data    (load_data),
      .o_data       (o_data_s),
      .terminal_cnt (tc_s),
      .wrapped      (wrapped_s)
`ifdef BCD_UPDOWN_CNTR_MATCH_EN
      ,
      .cmp_data     (cmp_data),
      .match        (match_s)
`endif
   );

   typedef struct {
      logic       clr, load, cnt, up;
      logic [7:0] ld;
      logic       tc_w, tc_s;
      logic [7:0] ew, es;
      logic       wr_w, wr_s;
   } vec_t;

   typedef struct {
      logic [7:0] ew, es;
      logic       wr_w, wr_s;
      string      tag;
   } exp_t;

   exp_t sbq[$];
   vec_t vecs[29];

   // Model state for the model-driven sequences (plain decimal integers).
   int vw = 0;
   int vs = 0;
   logic mwr_w = 1'b0;
   logic mwr_s = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // Drive one cycle of stimulus, check the combinational terminal count,
   // queue the post-edge expectation, then compare it after the edge.
   task automatic step(input logic c, input logic l, input logic n, input logic u,
                       input logic [7:0] d, input logic etw, input logic ets,
                       input logic [7:0] ew, input logic [7:0] es,
                       input logic eww, input logic ews, input string tag);
      exp_t e;
      @(negedge clk);
      clr = c; load = l; cnt = n; up = u; load_data = d;
      #1;
      check({tag, ".tc_w"}, 32'(tc_w), 32'(etw));
      check({tag, ".tc_s"}, 32'(tc_s), 32'(ets));
      sbq.push_back('{ew, es, eww, ews, tag});
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      check({e.tag, ".data_w"}, 32'(o_data_w), 32'(e.ew));
      check({e.tag, ".data_s"}, 32'(o_data_s), 32'(e.es));
      check({e.tag, ".wrapped_w"}, 32'(wrapped_w), 32'(e.wr_w));
      check({e.tag, ".wrapped_s"}, 32'(wrapped_s), 32'(e.wr_s));
   endtask

   // One counting cycle predicted by the integer model for both instances.
   task automatic model_step(input logic n, input logic u, input string tag);
      logic tw, ts;
      int   nw, ns;
      tw = n && (u ? (vw == 99) : (vw == 0));
      ts = n && (u ? (vs == 99) : (vs == 0));
      nw = vw;
      ns = vs;
      if (n) begin
         nw = u ? ((vw == 99) ? 0 : vw + 1) : ((vw == 0) ? 99 : vw - 1);
         ns = u ? ((vs == 99) ? 99 : vs + 1) : ((vs == 0) ? 0 : vs - 1);
      end
      if (tw) mwr_w = 1'b1;
      if (ts) mwr_s = 1'b1;
      step(1'b0, 1'b0, n, u, 8'h00, tw, ts, to_bcd(nw), to_bcd(ns), mwr_w, mwr_s, tag);
      vw = nw;
      vs = ns;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      //          clr   load  cnt   up    ld     tc_w  tc_s  ew     es     wr_w  wr_s
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h98, 1'b0, 1'b0, 8'h98, 8'h98, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h99, 8'h99, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 8'h99, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 8'h00, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h98, 8'h00, 1'b1, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h97, 8'h00, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h09, 8'h09, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 8'h99, 8'h99, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 8'h99, 1'b1, 1'b1};
      vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h55, 8'h55, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 8'h00, 1'b1, 1'b1};
      vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hAF, 1'b0, 1'b0, 8'h99, 8'h99, 1'b0, 1'b0};
      vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h39, 8'h39, 1'b0, 1'b0};
      vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 8'h12, 8'h12, 1'b0, 1'b0};
      vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h13, 8'h13, 1'b0, 1'b0};
      vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 8'h12, 1'b0, 1'b0};
      vecs[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h19, 1'b0, 1'b0, 8'h19, 8'h19, 1'b0, 1'b0};
      vecs[24] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h20, 8'h20, 1'b0, 1'b0};
      vecs[25] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h19, 8'h19, 1'b0, 1'b0};
      vecs[26] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 8'h99, 8'h99, 1'b0, 1'b0};
      vecs[27] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h50, 1'b0, 1'b0, 8'h50, 8'h50, 1'b0, 1'b0};
      vecs[28] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h50, 8'h50, 1'b0, 1'b0};

      // Power-up state before any clock edge.
      #1;
      check("powerup.data_w", 32'(o_data_w), 32'h0);
      check("powerup.wrapped_w", 32'(wrapped_w), 32'h0);
      check("powerup.data_s", 32'(o_data_s), 32'h0);

      for (int i = 0; i < 29; i++) begin
         step(vecs[i].clr, vecs[i].load, vecs[i].cnt, vecs[i].up, vecs[i].ld,
              vecs[i].tc_w, vecs[i].tc_s, vecs[i].ew, vecs[i].es,
              vecs[i].wr_w, vecs[i].wr_s, $sformatf("vec%0d", i));
      end

      // Full-range sweeps and random walk against the integer model.
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "sweep_clr");
      vw = 0; vs = 0; mwr_w = 1'b0; mwr_s = 1'b0;
      for (int i = 0; i < 105; i++) model_step(1'b1, 1'b1, $sformatf("up%0d", i));
      for (int i = 0; i < 110; i++) model_step(1'b1, 1'b0, $sformatf("dn%0d", i));
      for (int i = 0; i < 80; i++) begin
         model_step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    $sformatf("rnd%0d", i));
      end

`ifdef BCD_UPDOWN_CNTR_MATCH_EN
      // Registered match: high the cycle after the count reaches 42.
      cmp_data = 8'h42;
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0, 8'h40, 8'h40, 1'b0, 1'b0, "m_load");
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h41, 8'h41, 1'b0, 1'b0, "m41");
      check("m41.match_w", 32'(match_w), 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h42, 8'h42, 1'b0, 1'b0, "m42");
      check("m42.match_w", 32'(match_w), 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h43, 8'h43, 1'b0, 1'b0, "m43");
      check("m43.match_w", 32'(match_w), 32'h1);
      check("m43.match_s", 32'(match_s), 32'h1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h44, 8'h44, 1'b0, 1'b0, "m44");
      check("m44.match_w", 32'(match_w), 32'h0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "m_clr");
      check("m_clr.match_w", 32'(match_w), 32'h0);
`endif

      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
